// File: rtl/sram_bank_phased.sv
// Dual-read-port SRAM bank with one-hot word lines and a fixed five-phase operation sequencer.
// Optional macro SRAM_BANK_ONEHOT_CHECK_EN disables any port whose word bus is not one-hot and flags err.
module sram_bank_phased #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 32,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_write,
  input  logic [DEPTH-1:0] wordA,
  input  logic [DEPTH-1:0] wordB,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic             valid,
  output logic             busy,
  output logic             err,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    EXEC   = 3'd2,
    HOLD   = 3'd3,
    UNWIND = 3'd4
  } stateT;

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  stateT            stateReg, stateNext;
  logic [CNT_W-1:0] holdCntReg;
  logic             holdLast;

  logic             opWriteReg;
  logic [DEPTH-1:0] wordAReg, wordBReg;
  logic [WIDTH-1:0] dataReg;
  logic             portEnAReg, portEnBReg;
  logic             errReg;
  logic [WIDTH-1:0] outAReg, outBReg;
  logic             validReg;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] selA, selB, writeMask;
  logic [WIDTH-1:0] rowA [DEPTH];
  logic [WIDTH-1:0] rowB [DEPTH];
  logic [WIDTH-1:0] readA, readB;
  logic             enA, enB, errNext;

`ifdef SRAM_BANK_ONEHOT_CHECK_EN
  assign enA     = $onehot(wordA);
  assign enB     = $onehot(wordB);
  assign errNext = ~(enA & enB);
`else
  assign enA     = 1'b1;
  assign enB     = 1'b1;
  assign errNext = 1'b0;
`endif

  // A disabled port contributes no row select to either the write or the read path.
  assign selA      = portEnAReg ? wordAReg : '0;
  assign selB      = portEnBReg ? wordBReg : '0;
  assign writeMask = selA | selB;
  assign holdLast  = (holdCntReg == HOLD_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gRowSel
      assign rowA[gi] = selA[gi] ? mem[gi] : '0;
      assign rowB[gi] = selB[gi] ? mem[gi] : '0;
    end
  endgenerate

  // Wired-OR bitline: multi-hot selects merge rows, an empty select reads zero.
  always_comb begin
    readA = '0;
    readB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      readA = readA | rowA[i];
      readB = readB | rowB[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE:    if (start) stateNext = DATA;
      DATA:    stateNext = EXEC;
      EXEC:    stateNext = HOLD;
      HOLD:    if (holdLast) stateNext = UNWIND;
      UNWIND:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    phase = stateReg;
    if (stateReg != IDLE) busy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      holdCntReg <= '0;
      opWriteReg <= 1'b0;
      wordAReg   <= '0;
      wordBReg   <= '0;
      dataReg    <= '0;
      portEnAReg <= 1'b0;
      portEnBReg <= 1'b0;
      errReg     <= 1'b0;
      outAReg    <= '0;
      outBReg    <= '0;
      validReg   <= 1'b0;
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (start) begin
            opWriteReg <= op_write;
            wordAReg   <= wordA;
            wordBReg   <= wordB;
            portEnAReg <= enA;
            portEnBReg <= enB;
            errReg     <= errNext;
          end
        end
        DATA: dataReg <= in;
        EXEC: begin
          holdCntReg <= '0;
          if (!opWriteReg) begin
            outAReg  <= readA;
            outBReg  <= readB;
            validReg <= 1'b1;
          end
        end
        HOLD: begin
          if (holdLast) begin
            outAReg  <= '0;
            outBReg  <= '0;
            validReg <= 1'b0;
          end else begin
            holdCntReg <= holdCntReg + 1'b1;
          end
        end
        UNWIND: begin
          opWriteReg <= 1'b0;
          wordAReg   <= '0;
          wordBReg   <= '0;
          dataReg    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Reset takes priority over an in-flight EXEC write, so an aborted op never lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset)
        mem[i] <= '0;
      else if (stateReg == EXEC && opWriteReg && writeMask[i])
        mem[i] <= dataReg;
    end
  end

  assign outA  = outAReg;
  assign outB  = outBReg;
  assign valid = validReg;
  assign err   = errReg;

endmodule

// File: tb/tb_sram_bank_phased.sv
// Randomised scoreboard bench for sram_bank_phased against an array-level reference model.
module tb_sram_bank_phased;
  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int H     = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             opWrite = 1'b0;
  logic [DEPTH-1:0] wordA = '0;
  logic [DEPTH-1:0] wordB = '0;
  logic [WIDTH-1:0] inData = '0;
  logic [WIDTH-1:0] outA, outB;
  logic             valid, busy, err;
  logic [2:0]       phase;

  sram_bank_phased #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .start(start), .op_write(opWrite),
    .wordA(wordA), .wordB(wordB), .in(inData),
    .outA(outA), .outB(outB), .valid(valid), .busy(busy), .err(err), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } expT;

  expT              sbq[$];
  logic [WIDTH-1:0] model [DEPTH];
  int               checks = 0;
  int               fails = 0;
  int               opNum = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (op %0d, t=%0t)", name, act, exp, opNum, $time);
    end
  endtask

  function automatic bit portOk(input logic [DEPTH-1:0] w);
`ifdef SRAM_BANK_ONEHOT_CHECK_EN
    return $countones(w) == 1;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] modelRead(input logic [DEPTH-1:0] w);
    logic [WIDTH-1:0] r = '0;
    if (!portOk(w)) return '0;
    for (int i = 0; i < DEPTH; i++) if (w[i]) r |= model[i];
    return r;
  endfunction

  function automatic logic [DEPTH-1:0] oneHot(input int idx);
    logic [DEPTH-1:0] b = '0;
    b[idx] = 1'b1;
    return b;
  endfunction

  function automatic logic [DEPTH-1:0] randBus();
    int r = $urandom_range(0, 9);
    if (r < 7) return oneHot($urandom_range(0, DEPTH - 1));
    if (r == 7) return '0;
    return DEPTH'($urandom);
  endfunction

  // Monitor: every valid cycle consumes one expected read; outside valid the outputs must be null.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid: got outA=%h outB=%h with no read expected (t=%0t)", outA, outB, $time);
        end else begin
          e = sbq.pop_front();
          check("outA", 32'(outA), 32'(e.a));
          check("outB", 32'(outB), 32'(e.b));
        end
      end else begin
        check("idle_outA", 32'(outA), 32'h0);
        check("idle_outB", 32'(outB), 32'h0);
      end
    end
  end

  // Issue one op, model it, and follow the phase trace to completion.
  task automatic doOp(input bit wr, input logic [DEPTH-1:0] wa, input logic [DEPTH-1:0] wb,
                      input logic [WIDTH-1:0] d, input bit holdStart);
    logic       expErr;
    logic [2:0] expPhase;
    expT        e;
    opNum++;
    @(negedge clk);
    check("pre_busy", 32'(busy), 32'h0);
    start = 1'b1; opWrite = wr; wordA = wa; wordB = wb; inData = d;
    expErr = !(portOk(wa) && portOk(wb));
    if (wr) begin
      for (int i = 0; i < DEPTH; i++)
        if ((wa[i] && portOk(wa)) || (wb[i] && portOk(wb))) model[i] = d;
    end else begin
      e.a = modelRead(wa);
      e.b = modelRead(wb);
      for (int i = 0; i < H; i++) sbq.push_back(e);
    end
    $display("op %0d: %s wordA=%h wordB=%h in=%h", opNum, wr ? "WR" : "RD", wa, wb, d);
    for (int k = 0; k <= H + 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("err", 32'(err), 32'(expErr));
        if (!holdStart) start = 1'b0;
        wordA = DEPTH'($urandom); wordB = DEPTH'($urandom); opWrite = 1'($urandom);
      end
      if (k == 1) inData = WIDTH'($urandom);
      if (k == 0) expPhase = 3'd1;
      else if (k == 1) expPhase = 3'd2;
      else if (k < 2 + H) expPhase = 3'd3;
      else if (k == 2 + H) expPhase = 3'd4;
      else expPhase = 3'd0;
      check("phase", 32'(phase), 32'(expPhase));
      check("busy", 32'(busy), 32'(expPhase != 3'd0));
    end
    start = 1'b0;
    check("sb_drained", 32'(sbq.size()), 32'h0);
  endtask

  task automatic resetMidRead();
    expT e;
    opNum++;
    @(negedge clk);
    start = 1'b1; opWrite = 1'b0; wordA = oneHot(1); wordB = oneHot(1);
    e.a = modelRead(oneHot(1));
    e.b = e.a;
    sbq.push_back(e);
    $display("op %0d: RD row1 with reset during hold, expected %h", opNum, e.a);
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      check("abort_phase", 32'(phase), (k == 2) ? 32'd3 : 32'(k + 1));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_outA", 32'(outA), 32'h0);
    check("abort_valid", 32'(valid), 32'h0);
    check("abort_phase_idle", 32'(phase), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_sb", 32'(sbq.size()), 32'h0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_outA", 32'(outA), 32'h0);
    check("rst_outB", 32'(outB), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_phase", 32'(phase), 32'h0);
    for (int i = 0; i < DEPTH; i += 2) doOp(1'b0, oneHot(i), oneHot(i + 1), '0, 1'b0);

    doOp(1'b1, 32'h2, 32'h4, 16'hAAAA, 1'b0);
    doOp(1'b0, 32'h2, 32'h1, '0, 1'b0);
    doOp(1'b0, 32'h4, 32'h2, '0, 1'b0);

    doOp(1'b1, oneHot(5), oneHot(5), 16'hABCD, 1'b1);
    doOp(1'b0, oneHot(5), oneHot(4), '0, 1'b0);

    resetMidRead();
    doOp(1'b0, oneHot(1), oneHot(2), '0, 1'b0);

    doOp(1'b1, 32'h1, 32'h1, 16'h00F0, 1'b0);
    doOp(1'b1, 32'h2, 32'h2, 16'h0F00, 1'b0);
    doOp(1'b0, 32'h3, 32'h1, '0, 1'b0);

    doOp(1'b1, 32'h0, 32'h8, 16'h1234, 1'b0);
    doOp(1'b0, oneHot(3), oneHot(2), '0, 1'b0);
    doOp(1'b0, oneHot(0), oneHot(1), '0, 1'b0);

    for (int n = 0; n < 60; n++)
      doOp(1'($urandom), randBus(), randBus(), WIDTH'($urandom), 1'($urandom_range(0, 3) == 0));
    for (int i = 0; i < DEPTH; i += 2) doOp(1'b0, oneHot(i), oneHot(i + 1), '0, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
